// File: rtl/transpose_stream_ctrl.sv
// Streaming MxN matrix transposer: row-major elements in, column-major elements out,
// through two ping-pong register banks so one matrix can fill while the other drains.
module transpose_stream_ctrl #(
    parameter int M          = 2,
    parameter int N          = 2,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  frame_err
);

    localparam int DEPTH = M * N;
    localparam int WW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW    = (M > 1) ? $clog2(M) : 1;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;

    localparam logic [WW-1:0] WR_END  = WW'(DEPTH - 1);
    localparam logic [RW-1:0] ROW_END = RW'(M - 1);
    localparam logic [CW-1:0] COL_END = CW'(N - 1);

    logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

    logic [1:0]    full_q, full_d;
    logic          wrBank_q, wrBank_d;
    logic          rdBank_q, rdBank_d;
    logic [WW-1:0] wrCnt_q, wrCnt_d;
    logic [RW-1:0] rdRow_q, rdRow_d;
    logic [CW-1:0] rdCol_q, rdCol_d;
    logic          frameErr_q, frameErr_d;

    logic          wrFire, rdFire, wrEnd, rdEnd;
    logic [WW-1:0] rdAddr;

    assign s_ready   = !full_q[wrBank_q];
    assign m_valid   = full_q[rdBank_q];
    assign wrFire    = s_valid && s_ready;
    assign rdFire    = m_valid && m_ready;
    assign wrEnd     = (wrCnt_q == WR_END);
    assign rdEnd     = (rdCol_q == COL_END) && (rdRow_q == ROW_END);
    assign rdAddr    = WW'(int'(rdRow_q) * N + int'(rdCol_q));
    assign m_last    = m_valid && rdEnd;
    assign frame_err = frameErr_q;

    // Data is gated by m_valid so the output reads zero whenever no matrix is ready.
    assign m_data    = m_valid ? mem_q[rdBank_q][rdAddr] : '0;

    always_ff @(posedge clk) begin
        if (wrFire) begin
            mem_q[wrBank_q][wrCnt_q] <= s_data;
        end
    end

    // Fill and drain act on different banks, so both flag updates can land on one edge.
    always_comb begin
        full_d     = full_q;
        wrBank_d   = wrBank_q;
        rdBank_d   = rdBank_q;
        wrCnt_d    = wrCnt_q;
        rdRow_d    = rdRow_q;
        rdCol_d    = rdCol_q;
        frameErr_d = frameErr_q;

        if (wrFire) begin
            if (s_last != wrEnd) begin
                frameErr_d = 1'b1;
            end
            if (wrEnd) begin
                full_d[wrBank_q] = 1'b1;
                wrBank_d         = !wrBank_q;
                wrCnt_d          = '0;
            end else begin
                wrCnt_d = wrCnt_q + 1'b1;
            end
        end

        if (rdFire) begin
            if (rdEnd) begin
                full_d[rdBank_q] = 1'b0;
                rdBank_d         = !rdBank_q;
                rdRow_d          = '0;
                rdCol_d          = '0;
            end else if (rdRow_q == ROW_END) begin
                rdRow_d = '0;
                rdCol_d = rdCol_q + 1'b1;
            end else begin
                rdRow_d = rdRow_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            wrBank_q   <= 1'b0;
            rdBank_q   <= 1'b0;
            wrCnt_q    <= '0;
            rdRow_q    <= '0;
            rdCol_q    <= '0;
            frameErr_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wrBank_q   <= wrBank_d;
            rdBank_q   <= rdBank_d;
            wrCnt_q    <= wrCnt_d;
            rdRow_q    <= rdRow_d;
            rdCol_q    <= rdCol_d;
            frameErr_q <= frameErr_d;
        end
    end

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Directed bench for transpose_stream_ctrl with M=2, N=3, DATA_WIDTH=4; inputs are
// driven and outputs sampled on the falling edge against a queue of expected elements.
module tb_transpose_stream_ctrl;

    typedef struct {
        logic [3:0] data;
        logic       last;
        logic       isEnd;
    } elem_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_data;
    logic       m_last;
    logic       frame_err;

    elem_t inQ[$];
    elem_t expQ[$];

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycleNo, inCount, outCount, gapCount, sReadyLowCount;
    int firstValidCycle, endAcceptCycle;
    bit outStarted, prevLastHs;

    transpose_stream_ctrl #(.M(2), .N(3), .DATA_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue one 2x3 matrix with element e = (base+e) mod 16; lastIdx picks where s_last goes.
    task automatic pushMatrix(input int base, input int lastIdx);
        elem_t e;
        for (int i = 0; i < 6; i++) begin
            e.data  = 4'((base + i) % 16);
            e.last  = (i == lastIdx);
            e.isEnd = (i == 5);
            inQ.push_back(e);
        end
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 2; r++) begin
                e.data  = 4'((base + r * 3 + c) % 16);
                e.last  = (c == 2) && (r == 1);
                e.isEnd = 1'b0;
                expQ.push_back(e);
            end
        end
    endtask

    task automatic clearStats();
        cycleNo         = 0;
        inCount         = 0;
        outCount        = 0;
        gapCount        = 0;
        sReadyLowCount  = 0;
        firstValidCycle = -1;
        endAcceptCycle  = -1;
        outStarted      = 1'b0;
        prevLastHs      = 1'b0;
    endtask

    task automatic resetDut();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset s_ready", s_ready, 1);
        checkOutput("reset m_valid", m_valid, 0);
        checkOutput("reset m_last", m_last, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset m_data", m_data, 0);
        rst = 1'b0;
        inQ.delete();
        expQ.delete();
        clearStats();
    endtask

    // One clock: sample outputs, decide this edge's handshakes, then wait for the next fall.
    // mode 0 holds m_ready low, mode 1 holds it high, anything else randomises it.
    task automatic applyStimulus(input int mode);
        case (mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (prevLastHs) begin
            checkOutput("s_ready after m_last", s_ready, 1);
        end
        prevLastHs = 1'b0;
        if (m_valid) begin
            if (firstValidCycle < 0) firstValidCycle = cycleNo;
            if (expQ.size() == 0) begin
                checkOutput("unexpected m_valid", m_valid, 0);
            end else begin
                checkOutput("m_data", m_data, expQ[0].data);
                checkOutput("m_last", m_last, expQ[0].last);
                if (m_ready) begin
                    prevLastHs = expQ[0].last;
                    outStarted = 1'b1;
                    expQ.pop_front();
                    outCount++;
                end
            end
        end else if (outStarted && expQ.size() > 0) begin
            gapCount++;
        end
        if (!s_ready) sReadyLowCount++;
        if (inQ.size() > 0) begin
            s_valid = 1'b1;
            s_data  = inQ[0].data;
            s_last  = inQ[0].last;
            if (s_ready) begin
                if (inQ[0].isEnd) endAcceptCycle = cycleNo;
                inQ.pop_front();
                inCount++;
            end
        end else begin
            s_valid = 1'b0;
            s_data  = '0;
            s_last  = 1'b0;
        end
        @(negedge clk);
        cycleNo++;
    endtask

    task automatic runCycles(input int n, input int mode);
        for (int i = 0; i < n; i++) applyStimulus(mode);
    endtask

    task automatic runToDone(input int budget, input int mode);
        int n = 0;
        while ((inQ.size() > 0 || expQ.size() > 0) && n < budget) begin
            applyStimulus(mode);
            n++;
        end
        checkOutput("pending elements", inQ.size() + expQ.size(), 0);
        m_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        $display("[TB] single matrix 1..6");
        resetDut();
        pushMatrix(1, 5);
        runToDone(100, 1);
        checkOutput("latency", firstValidCycle - endAcceptCycle, 1);
        checkOutput("single out count", outCount, 6);
        checkOutput("single frame_err", frame_err, 0);

        $display("[TB] back-to-back matrices");
        resetDut();
        pushMatrix(1, 5);
        pushMatrix(7, 5);
        runToDone(100, 1);
        checkOutput("b2b s_ready low cycles", sReadyLowCount, 0);
        checkOutput("b2b gap cycles", gapCount, 0);
        checkOutput("b2b out count", outCount, 12);

        $display("[TB] backpressure with three matrices");
        resetDut();
        pushMatrix(1, 5);
        pushMatrix(7, 5);
        pushMatrix(13, 5);
        runCycles(20, 0);
        checkOutput("bp accepted", inCount, 12);
        checkOutput("bp s_ready", s_ready, 0);
        checkOutput("bp m_valid", m_valid, 1);
        runToDone(200, 1);
        checkOutput("bp total accepted", inCount, 18);
        checkOutput("bp out count", outCount, 18);

        $display("[TB] random m_ready over 20 matrices");
        resetDut();
        for (int k = 0; k < 20; k++) pushMatrix(k * 5 + 2, 5);
        runToDone(2000, 2);
        checkOutput("random out count", outCount, 120);
        checkOutput("random frame_err", frame_err, 0);

        $display("[TB] early s_last");
        resetDut();
        pushMatrix(3, 3);
        runToDone(100, 1);
        checkOutput("early s_last frame_err", frame_err, 1);
        pushMatrix(9, 5);
        runToDone(100, 1);
        checkOutput("frame_err sticky", frame_err, 1);

        $display("[TB] missing s_last");
        resetDut();
        pushMatrix(4, -1);
        runToDone(100, 1);
        checkOutput("missing s_last frame_err", frame_err, 1);

        $display("[TB] reset mid-operation");
        resetDut();
        pushMatrix(1, 5);
        for (int i = 0; i < 3; i++) begin
            elem_t e;
            e.data  = 4'(i + 10);
            e.last  = (i == 0);
            e.isEnd = 1'b0;
            inQ.push_back(e);
        end
        runCycles(12, 0);
        checkOutput("pre-reset accepted", inCount, 9);
        checkOutput("pre-reset frame_err", frame_err, 1);
        runCycles(3, 1);
        checkOutput("pre-reset drained", outCount, 3);
        resetDut();
        pushMatrix(1, 5);
        runToDone(100, 1);
        checkOutput("post-reset out count", outCount, 6);
        checkOutput("post-reset frame_err", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/transpose_stream_ctrl.md
Name: transpose_stream_ctrl

Overview:
- Streaming front-end for matrix transposition.
- Accepts an MxN matrix one element per cycle in row-major order over a valid/ready interface, stores it in a two-bank (ping-pong) register buffer, and replays it in column-major order on a valid/ready output.
- One bank can fill while the other drains, giving sustained one-element-per-cycle throughput. Sits between the element-serial producer and any consumer that needs transposed ordering.

Parameters:
- M, 2, rows of the input matrix (>=1)
- N, 2, columns of the input matrix (>=1)
- DATA_WIDTH, 2, bits per element

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  input element valid
- s_ready  output  1  block can accept an input element
- s_data  input  DATA_WIDTH  input element, row-major order
- s_last  input  1  producer marks final element of a matrix (checked only)
- m_valid  output  1  output element valid
- m_ready  input  1  consumer accepts output element
- m_data  output  DATA_WIDTH  output element, column-major order
- m_last  output  1  high with final output element of a matrix
- frame_err  output  1  sticky: s_last disagreed with internal element count

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: s_ready=1, m_valid=0, m_last=0, frame_err=0, m_data=0.
- Reset clears both bank-full flags, both element counters, and wr_bank=rd_bank=0.
- Reset mid-operation discards any partial or undrained matrix. Buffer contents need not be cleared.
- Storage: two banks, each M*N x DATA_WIDTH registers. Element (i,j) is stored at address i*N+j.
- Write side:
  - Input handshake is s_valid && s_ready at a rising edge.
  - s_ready = !full[wr_bank], combinational from registered flags.
  - Each accepted element is written to bank wr_bank at the write counter, then the counter increments.
  - On accepting element M*N-1: set full[wr_bank], toggle wr_bank, reset the write counter to 0.
- Frame check:
  - frame_err is set if s_last=1 on an accepted element whose index is not M*N-1.
  - frame_err is also set if s_last=0 on the element at index M*N-1.
  - Framing is always governed by the counter, never by s_last.
  - frame_err clears only on rst.
- Read side:
  - m_valid = full[rd_bank].
  - The read counter runs as (col c, row r), with r incrementing fastest: r=0..M-1 for each c=0..N-1.
  - m_data = bank[rd_bank][r*N+c], combinational from storage.
  - m_last = m_valid && (c==N-1) && (r==M-1).
  - Output handshake is m_valid && m_ready at a rising edge. It advances the counter.
  - On the m_last handshake: clear full[rd_bank], toggle rd_bank, reset (c,r) to (0,0).
- Hold rule: while m_valid && !m_ready, m_data and m_last are held stable. The storage of a full bank is never written.
- Latency: m_valid asserts in the cycle after the edge that accepted input element M*N-1 (1 cycle), provided the target bank is the read bank.
- Simultaneous events:
  - Fill completion on one bank and drain completion on the other in the same edge are independent; both take effect.
  - Writer and reader never address the same bank in one cycle. The writer only targets non-full banks; the reader only targets full banks.
- Backpressure:
  - With both banks full, s_ready=0.
  - s_ready returns to 1 in the cycle after the m_last handshake frees a bank.
  - No element is ever dropped or duplicated.
- Degenerate sizes:
  - M=1 or N=1 gives output order equal to input order.
  - M=N=1 gives m_last high on every output element.
- Counter widths: clog2(M*N) minimum 1 bit for the write counter; clog2(M) and clog2(N) minimum 1 bit for the read counter.

Test Plan:
- M=2,N=3,DW=4; stream 1,2,3,4,5,6 with s_last on the 6th, m_ready=1 -> output 1,4,2,5,3,6; m_last only with 6; m_valid rises 1 cycle after input 6 accepted; frame_err=0.
- Same config; back-to-back matrices A=1..6 and B=7..12 (values 7,8,9,10,11,12), m_ready=1 -> s_ready stays 1; output 1,4,2,5,3,6,7,10,8,11,9,12 with no gap cycles after the first.
- Hold m_ready=0; stream three matrices -> s_ready drops to 0 after 12 accepted elements. Release m_ready -> the first two matrices are output transposed. s_ready goes high the cycle after the first m_last handshake, and the third matrix is then accepted and output correctly.
- Random m_ready toggling (~50%) over 20 matrices -> outputs match a scoreboard transpose exactly; m_data stable whenever m_valid && !m_ready.
- s_last asserted on element 4 of 6 -> frame_err=1 and stays 1; the matrix still closes at element 6 and outputs the correct transpose.
- Assert rst after 3 elements of a matrix while the other bank is half-drained -> the next cycle shows m_valid=0, s_ready=1, frame_err=0; a fresh matrix 1..6 then outputs 1,4,2,5,3,6.
